// File: rtl/param_rom_stream_ctrl_if.sv
// Bundles the control, ROM and output-stream signals of param_rom_stream_ctrl.
// Output stream: a word transfers on any cycle where data_out_valid && data_out_ready; data_out/data_out_valid hold while waiting.
interface param_rom_stream_ctrl_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [15:0]           num_passes;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ce;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [1:0]            dbg_state;

  modport master (
    input  start, num_passes, rom_q, data_out_ready,
    output busy, done, rom_addr, rom_ce, data_out, data_out_valid, dbg_state
  );

  modport slave (
    output start, num_passes, rom_q, data_out_ready,
    input  busy, done, rom_addr, rom_ce, data_out, data_out_valid, dbg_state
  );
endinterface

// File: rtl/param_rom_stream_ctrl.sv
// Streams num_passes sweeps of a fixed-latency ROM through a credit-controlled output FIFO.
// Optional stall counter output is enabled by defining PARAM_STREAM_PERF_EN.
module param_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 512,
  parameter int DEPTH       = 24,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PARAM_STREAM_PERF_EN
  output logic [31:0] stall_count,
`endif
  param_rom_stream_ctrl_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e                 state_q;
  logic                   busy_q, ce_q, done_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [15:0]            pass_q, passes_q;
  logic [ROM_LATENCY-1:0] tag_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;

  logic             valid, pop, push, issue, last_issue;
  logic [SUM_W-1:0] in_flight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) in_flight = in_flight + SUM_W'(tag_q[i]);
  end

  assign valid = (count_q != '0);
  assign pop   = valid && bus.data_out_ready;
  assign push  = tag_q[ROM_LATENCY-1];
  // Words already buffered plus words still in the ROM pipe must fit after this cycle's pop.
  assign issue = (state_q == S_STREAM) &&
                 ((SUM_W'(count_q) + in_flight - SUM_W'(pop)) < SUM_W'(FIFO_DEPTH));
  assign last_issue = issue && (addr_q == ADDR_WIDTH'(DEPTH - 1)) &&
                      (pass_q == passes_q - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      ce_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      tag_q  <= (tag_q << 1) | ROM_LATENCY'(issue);
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            passes_q <= bus.num_passes;
            pass_q   <= '0;
            addr_q   <= '0;
            if (bus.num_passes == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_STREAM;
              busy_q  <= 1'b1;
              ce_q    <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (issue) begin
            if (addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
              addr_q <= '0;
              pass_q <= pass_q + 16'd1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
            if (last_issue) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((in_flight == '0) && !valid) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ce_q    <= 1'b0;
        end
      endcase
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; emptiness is carried by count_q and data_out is gated by it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rom_q;
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.rom_ce         = ce_q;
  assign bus.rom_addr       = addr_q;
  assign bus.data_out_valid = valid;
  assign bus.data_out       = valid ? mem_q[rd_ptr_q] : '0;
  assign bus.dbg_state      = state_q;

`ifdef PARAM_STREAM_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && bus.start) begin
      stall_q <= '0;
    end else if (valid && !bus.data_out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: doc/param_rom_stream_ctrl.md
PARAM_ROM_STREAM_CTRL -- requirements
Module: param_rom_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning ROM word width (PRECISION_0 x TENSOR_SIZE_DIM_0).
REQ-002 SHALL have parameter DEPTH, default 24, meaning number of ROM words per pass.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH)+1, meaning ROM address width.
REQ-004 SHALL have parameter ROM_LATENCY, default 2, meaning cycles from address/ce to valid rom_q.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries; legal range is FIFO_DEPTH >= ROM_LATENCY+2.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning reset; asynchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a stream.
REQ-009 SHALL have port num_passes, input, 16 bits, meaning full ROM sweeps to emit, sampled with start.
REQ-010 SHALL have port busy, output, 1 bit, meaning state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when the stream completes.
REQ-012 SHALL have port rom_addr, output, ADDR_WIDTH bits, meaning ROM address.
REQ-013 SHALL have port rom_ce, output, 1 bit, meaning ROM clock enable.
REQ-014 SHALL have port rom_q, input, DATA_WIDTH bits, meaning ROM read data.
REQ-015 SHALL have port data_out, output, DATA_WIDTH bits, meaning FIFO head word.
REQ-016 SHALL have port data_out_valid, output, 1 bit, meaning the FIFO is non-empty.
REQ-017 SHALL have port data_out_ready, input, 1 bit, meaning the consumer accepts data.

Function
REQ-018 SHALL implement FSM IDLE -> STREAM -> DRAIN -> IDLE; start is ignored unless in IDLE.
REQ-019 SHALL, on start in IDLE with num_passes=0, pulse done in the next cycle, stay IDLE, and issue no reads.
REQ-020 SHALL hold rom_ce=1 in STREAM and DRAIN and rom_ce=0 in IDLE, so the ROM pipeline never stalls and each read returns exactly ROM_LATENCY cycles after issue.
REQ-021 SHALL issue a read in STREAM when fifo_count + in_flight - pop < FIFO_DEPTH, where pop = data_out_valid AND data_out_ready in the same cycle.
REQ-022 SHALL advance rom_addr after each issue and wrap from DEPTH-1 to 0, incrementing the pass counter on wrap.
REQ-023 SHALL track in-flight reads with a ROM_LATENCY-deep valid shift register and write rom_q into the FIFO when the tag exits.
REQ-024 SHALL enter DRAIN after the final read (num_passes x DEPTH total) is issued.
REQ-025 SHALL exit DRAIN when in_flight=0 and the FIFO is empty, pulse done for one cycle, and return to IDLE.
REQ-026 SHALL, with start asserted in cycle 0, present address 0 in cycle 1 and raise data_out_valid in cycle ROM_LATENCY+2.
REQ-027 SHALL sustain one beat per cycle with no bubbles while data_out_ready is held high.
REQ-028 SHALL hold data_out and data_out_valid stable while valid=1 and ready=0, and SHALL never overflow or drop a word.
REQ-029 SHALL permit a FIFO push and pop in the same cycle, including when the FIFO is full.

Reset
REQ-030 SHALL, on rst (including mid-stream), force IDLE and set busy=0, done=0, rom_ce=0, rom_addr=0, data_out=0 and data_out_valid=0, clearing the FIFO, in-flight tags and pass counter.
REQ-031 SHALL discard any in-flight ROM data returning after reset deasserts.

Configuration
REQ-032 SHALL, with PARAM_STREAM_PERF_EN defined, add output stall_count (32 bits): it is cleared on start and increments each cycle data_out_valid=1 and data_out_ready=0, saturating at all-ones.
REQ-033 SHALL, without PARAM_STREAM_PERF_EN, omit the stall_count port and its logic entirely; all other behaviour is identical.

Verification
REQ-034 SHALL cover start with num_passes=1 and ready=1: words for addresses 0..23 appear in order in cycles 4..27, with done pulsing once after the last beat.
REQ-035 SHALL cover num_passes=3 with ready=1: 72 beats, the address sequence wraps 23->0 twice, and done pulses exactly once.
REQ-036 SHALL cover ready held low from cycle 2 to cycle 20: at most 4 words are buffered, no reads are issued while credits are exhausted, and after release the full sequence arrives with none lost or duplicated.
REQ-037 SHALL cover num_passes=0: done pulses in cycle 1, rom_ce stays 0, and data_out_valid never rises.
REQ-038 SHALL cover rst asserted at beat 10 of a pass followed by a new start: outputs go to their reset values immediately, and the new stream begins again at address 0 with no stale words.
REQ-039 SHALL cover, with PARAM_STREAM_PERF_EN, ready toggled 1/0 every cycle over one pass: stall_count equals the number of valid-and-not-ready cycles (23 or 24).
